// File: rtl/btn_cmd_issuer.sv
// btn_cmd_issuer: debounced push-button that issues one captured switch
// command per press over a valid/ready handshake.
module btn_cmd_issuer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_go,
  input  logic [15:0] sw,
  output logic [31:0] addr_out,
  output logic [31:0] data_out,
  output logic [1:0]  cmd_out,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        busy,
  output logic [7:0]  issue_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RELEASE
  } state_t;

  state_t        state;

  logic          btn_m;
  logic          btn_s;
  logic [15:0]   sw_m;
  logic [15:0]   sw_s;

  logic [CW-1:0] cnt;
  logic          deb;
  logic          deb_q;
  logic          press;

  logic [7:0]    addr_q;
  logic [5:0]    data_q;

  // Two-flop synchronisers for the asynchronous button and switches.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      btn_m <= btn_go;
      btn_s <= btn_m;
      sw_m  <= sw;
      sw_s  <= sw_m;
    end
  end

  // Debounce: flip deb only after a full run of mismatching samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
    end else begin
      deb_q <= deb;
      if (btn_s == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        deb <= ~deb;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = deb & ~deb_q;

  // Command FSM: capture on press, hold until accepted, await release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cmd_valid   <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cmd_out     <= '0;
      issue_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (press) begin
            addr_q    <= sw_s[7:0];
            data_q    <= sw_s[13:8];
            cmd_out   <= sw_s[15:14];
            cmd_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid   <= 1'b0;
            issue_count <= issue_count + 8'd1;
            state       <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (!deb) begin
            state <= IDLE;
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign addr_out = {24'b0, addr_q};
  assign data_out = {26'b0, data_q};
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_btn_cmd_issuer.sv
// tb_btn_cmd_issuer: directed scenarios plus random stimulus, checked
// every cycle against a window-based behavioural model.
module tb_btn_cmd_issuer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_go;
  logic [15:0] sw;
  logic [31:0] addr_out;
  logic [31:0] data_out;
  logic [1:0]  cmd_out;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        busy;
  logic [7:0]  issue_count;

  always #5 clk = ~clk;

  btn_cmd_issuer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_go      (btn_go),
    .sw          (sw),
    .addr_out    (addr_out),
    .data_out    (data_out),
    .cmd_out     (cmd_out),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .busy        (busy),
    .issue_count (issue_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  // Reference model: two-sample delay line, deb flips once the last D
  // synchronised samples all disagree with it, and a command is
  // pending / awaiting release as plain flags.
  bit          m_bm, m_bs;
  logic [15:0] m_swm, m_sws;
  bit          m_deb, m_debq;
  bit          hist[$];
  bit          m_valid, m_hold;
  logic [15:0] m_cap;
  logic [7:0]  m_cnt;
  bit          m_press, m_flip;

  always @(posedge clk) begin
    if (reset) begin
      m_bm = 0; m_bs = 0; m_swm = '0; m_sws = '0;
      m_deb = 0; m_debq = 0; hist.delete();
      m_valid = 0; m_hold = 0; m_cap = '0; m_cnt = '0;
    end else begin
      m_press = m_deb && !m_debq;
      if (m_valid) begin
        if (cmd_ready) begin
          m_valid = 0;
          m_cnt   = m_cnt + 8'd1;
          m_hold  = 1;
        end
      end else if (m_hold) begin
        if (!m_deb) m_hold = 0;
      end else if (m_press) begin
        m_cap   = m_sws;
        m_valid = 1;
      end
      hist.push_back(m_bs);
      if (hist.size() > D) void'(hist.pop_front());
      m_flip = (hist.size() == D);
      foreach (hist[i]) if (hist[i] == m_deb) m_flip = 0;
      m_debq = m_deb;
      if (m_flip) m_deb = !m_deb;
      m_bs  = m_bm;
      m_bm  = btn_go;
      m_sws = m_swm;
      m_swm = sw;
    end
  end

  bit prev_v = 0;
  int rises  = 0;

  task automatic step();
    @(negedge clk);
    chk("valid", cmd_valid, m_valid);
    chk("busy", busy, m_valid || m_hold);
    chk("addr", addr_out, {24'b0, m_cap[7:0]});
    chk("data", data_out, {26'b0, m_cap[13:8]});
    chk("cmd", cmd_out, m_cap[15:14]);
    chk("count", issue_count, m_cnt);
    if (cmd_valid && !prev_v) rises++;
    prev_v = cmd_valid;
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    while (!cmd_valid && n < lim) begin
      step();
      n++;
    end
    chk("wait_valid", cmd_valid, 1);
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask

  int vcyc;
  bit seen;
  int seg;

  initial begin
    reset = 1; btn_go = 0; sw = '0; cmd_ready = 0;
    repeat (3) step();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", addr_out, 0);
    chk("rst_count", issue_count, 0);
    reset = 0;
    repeat (2) step();

    // basic issue: 7 edges from first sampling edge
    sw = 16'hC5A3; cmd_ready = 1;
    repeat (3) step();
    btn_go = 1;
    repeat (6) step();
    chk("lat_early", cmd_valid, 0);
    step();
    chk("lat_valid", cmd_valid, 1);
    chk("basic_addr", addr_out, 32'hA3);
    chk("basic_data", data_out, 32'h05);
    chk("basic_cmd", cmd_out, 2'b11);
    step();
    chk("one_cycle", cmd_valid, 0);
    chk("basic_count", issue_count, 1);
    btn_go = 0;
    repeat (12) step();
    chk("basic_idle", busy, 0);

    // backpressure with switch change mid-wait
    cmd_ready = 0; sw = 16'h4321;
    repeat (3) step();
    btn_go = 1;
    wait_valid(50);
    vcyc = 1;
    for (int i = 2; i <= 21; i++) begin
      if (i == 10) sw = 16'hFFFF;
      step();
      if (cmd_valid) vcyc++;
    end
    cmd_ready = 1;
    step();
    if (cmd_valid) vcyc++;
    chk("bp_len", vcyc, 21);
    chk("bp_addr", addr_out, 32'h21);
    chk("bp_data", data_out, 32'h03);
    chk("bp_cmd", cmd_out, 2'b01);
    chk("bp_count", issue_count, 2);
    btn_go = 0;
    repeat (12) step();

    // bounce rejection
    seen = 0;
    repeat (6) begin
      btn_go = 1;
      repeat (3) begin step(); if (busy || cmd_valid) seen = 1; end
      btn_go = 0;
      repeat (3) begin step(); if (busy || cmd_valid) seen = 1; end
    end
    repeat (8) begin step(); if (busy || cmd_valid) seen = 1; end
    chk("bounce_seen", seen, 0);

    // held button, then release and re-press
    do_reset();
    rises = 0;
    btn_go = 1;
    repeat (100) step();
    chk("held_cmds", rises, 1);
    btn_go = 0;
    repeat (10) step();
    btn_go = 1;
    repeat (20) step();
    chk("repress_cmds", rises, 2);
    chk("repress_count", issue_count, 2);
    btn_go = 0;
    repeat (12) step();

    // reset during ISSUE with the button still held
    cmd_ready = 0;
    btn_go = 1;
    wait_valid(50);
    reset = 1;
    step();
    chk("rmid_valid", cmd_valid, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_addr", addr_out, 0);
    chk("rmid_data", data_out, 0);
    chk("rmid_cmd", cmd_out, 0);
    chk("rmid_count", issue_count, 0);
    reset = 0;
    wait_valid(50);
    chk("rmid_pend_count", issue_count, 0);
    cmd_ready = 1;
    step();
    chk("rmid_accept", issue_count, 1);
    btn_go = 0;
    repeat (12) step();

    // counter wrap after 256 accepts
    do_reset();
    for (int i = 0; i < 256; i++) begin
      sw = 16'($urandom);
      btn_go = 1;
      wait_valid(30);
      btn_go = 0;
      repeat (9) step();
      if (i == 254) chk("pre_wrap", issue_count, 255);
    end
    chk("wrap", issue_count, 0);

    // random traffic
    do_reset();
    seg = 0;
    for (int c = 0; c < 4000; c++) begin
      sw = 16'($urandom);
      cmd_ready = ($urandom_range(3) != 0);
      if (seg == 0) begin
        btn_go = ~btn_go;
        seg = $urandom_range(12, 1);
      end
      seg--;
      reset = ($urandom_range(599) == 0);
      step();
    end
    reset = 0;
    btn_go = 0;
    repeat (12) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
